// File: rtl/matrix_vertex_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_vertex_feeder
// Purpose  : Assembles a 4x4 matrix and a vertex FIFO from a 16-bit word
//            stream, feeds matrixmult, and registers its products.
// Revision : 1.0  initial release
// ============================================================================
module matrix_vertex_feeder #(
  parameter int VTX_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start_new,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic                         i_wr_is_matrix,
  input  logic [15:0]                  i_wr_data,
  output logic [15:0]                  o_row0_0,
  output logic [15:0]                  o_row0_1,
  output logic [15:0]                  o_row0_2,
  output logic [15:0]                  o_row0_3,
  output logic [15:0]                  o_row1_0,
  output logic [15:0]                  o_row1_1,
  output logic [15:0]                  o_row1_2,
  output logic [15:0]                  o_row1_3,
  output logic [15:0]                  o_row2_0,
  output logic [15:0]                  o_row2_1,
  output logic [15:0]                  o_row2_2,
  output logic [15:0]                  o_row2_3,
  output logic [15:0]                  o_row3_0,
  output logic [15:0]                  o_row3_1,
  output logic [15:0]                  o_row3_2,
  output logic [15:0]                  o_row3_3,
  output logic [15:0]                  o_pixelinT_0,
  output logic [15:0]                  o_pixelinT_1,
  output logic [15:0]                  o_pixelinT_2,
  output logic [15:0]                  o_pixelinT_3,
  input  logic [31:0]                  i_pixelout_0,
  input  logic [31:0]                  i_pixelout_1,
  input  logic [31:0]                  i_pixelout_2,
  input  logic [31:0]                  i_pixelout_3,
  output logic [31:0]                  o_out_pixel_0,
  output logic [31:0]                  o_out_pixel_1,
  output logic [31:0]                  o_out_pixel_2,
  output logic [31:0]                  o_out_pixel_3,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_matrix_loaded,
  output logic [$clog2(VTX_DEPTH):0]   o_vtx_count
);

  localparam int            c_AW   = $clog2(VTX_DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(VTX_DEPTH);

  logic [15:0]     r_mat [16];
  logic [3:0]      r_mat_idx;
  logic            r_loaded;
  logic [1:0]      r_comp_idx;
  logic [47:0]     r_stage;
  logic [63:0]     r_fifo [VTX_DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW:0]   r_count;
  logic [31:0]     r_out [4];
  logic            r_out_valid;

  logic            w_empty;
  logic            w_full;
  logic            w_idle;
  logic            w_mat_acc;
  logic            w_vtx_acc;
  logic            w_push;
  logic            w_pop;
  logic [63:0]     w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  // Matrix writes wait until nothing is in flight so every result uses one matrix.
  assign w_idle    = w_empty && (r_comp_idx == 2'd0) && !r_out_valid;
  assign o_wr_ready = !i_reset && !i_start_new &&
                      (i_wr_is_matrix ? w_idle : (r_loaded && !w_full));
  assign w_mat_acc = i_wr_valid && o_wr_ready && i_wr_is_matrix;
  assign w_vtx_acc = i_wr_valid && o_wr_ready && !i_wr_is_matrix;
  assign w_push    = w_vtx_acc && (r_comp_idx == 2'd3);
  assign w_pop     = !i_start_new && !w_empty && (!r_out_valid || i_out_ready);
  assign w_head    = r_fifo[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) r_mat[i] <= '0;
      r_mat_idx <= '0;
      r_loaded  <= 1'b0;
    end else if (i_start_new) begin
      r_mat_idx <= '0;
      r_loaded  <= 1'b0;
    end else if (w_mat_acc) begin
      r_mat[r_mat_idx] <= i_wr_data;
      if (r_mat_idx == 4'd0) r_loaded <= 1'b0;
      if (r_mat_idx == 4'd15) r_loaded <= 1'b1;
      r_mat_idx <= r_mat_idx + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < VTX_DEPTH; i++) r_fifo[i] <= '0;
      r_comp_idx <= '0;
      r_stage    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (i_start_new) begin
      r_comp_idx <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_vtx_acc) begin
        r_comp_idx <= r_comp_idx + 2'd1;
        case (r_comp_idx)
          2'd0:    r_stage[15:0]  <= i_wr_data;
          2'd1:    r_stage[31:16] <= i_wr_data;
          2'd2:    r_stage[47:32] <= i_wr_data;
          default: r_fifo[r_wr_ptr] <= {i_wr_data, r_stage};
        endcase
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The head is on the matrixmult operands, so its product is captured on pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
      r_out_valid <= 1'b0;
    end else if (i_start_new) begin
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out[0]    <= i_pixelout_0;
      r_out[1]    <= i_pixelout_1;
      r_out[2]    <= i_pixelout_2;
      r_out[3]    <= i_pixelout_3;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_row0_0 = r_mat[0];
  assign o_row0_1 = r_mat[1];
  assign o_row0_2 = r_mat[2];
  assign o_row0_3 = r_mat[3];
  assign o_row1_0 = r_mat[4];
  assign o_row1_1 = r_mat[5];
  assign o_row1_2 = r_mat[6];
  assign o_row1_3 = r_mat[7];
  assign o_row2_0 = r_mat[8];
  assign o_row2_1 = r_mat[9];
  assign o_row2_2 = r_mat[10];
  assign o_row2_3 = r_mat[11];
  assign o_row3_0 = r_mat[12];
  assign o_row3_1 = r_mat[13];
  assign o_row3_2 = r_mat[14];
  assign o_row3_3 = r_mat[15];

  assign o_pixelinT_0 = w_head[15:0];
  assign o_pixelinT_1 = w_head[31:16];
  assign o_pixelinT_2 = w_head[47:32];
  assign o_pixelinT_3 = w_head[63:48];

  assign o_out_pixel_0   = r_out[0];
  assign o_out_pixel_1   = r_out[1];
  assign o_out_pixel_2   = r_out[2];
  assign o_out_pixel_3   = r_out[3];
  assign o_out_valid     = r_out_valid;
  assign o_matrix_loaded = r_loaded;
  assign o_vtx_count     = r_count;

endmodule
`default_nettype wire

// File: doc/matrix_vertex_feeder.md
# matrix_vertex_feeder

Upstream operand stage for the combinational 4x4 × 4x1 `matrixmult` datapath. It accepts a serial 16-bit word stream, such as MicroBlaze writes, and assembles a 16-coefficient transform matrix plus a queue of 4-component vertices. It drives the `matrixmult` operand ports from its matrix registers and the vertex FIFO head. It registers the four 32-bit `pixelout` results behind a valid/ready output handshake, so vertices stream through one per cycle under no backpressure.

## Interface
- `VTX_DEPTH`, default 4: vertex FIFO depth in vertices; power of two, ≥2.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start_new` input 1: synchronous clear of counters, FIFO and output register; matrix coefficient values are kept, `matrix_loaded` is cleared.
- `wr_valid` input 1: input word valid.
- `wr_ready` output 1: input word accepted when `wr_valid && wr_ready`.
- `wr_is_matrix` input 1: 1 = matrix coefficient word, 0 = vertex component word.
- `wr_data` input 16: coefficient or component, unsigned.
- `row{r}_{c}` output 16 each (r,c = 0..3): matrix coefficients to `matrixmult`.
- `pixelinT_{c}` output 16 each (c = 0..3): FIFO head vertex to `matrixmult`.
- `pixelout_{r}` input 32 each (r = 0..3): products returned by `matrixmult`.
- `out_pixel_{r}` output 32 each: registered results.
- `out_valid` output 1: registered result available.
- `out_ready` input 1: consumer accepts when `out_valid && out_ready`.
- `matrix_loaded` output 1: all 16 coefficients written.
- `vtx_count` output log2(VTX_DEPTH)+1: FIFO occupancy.

## Operation
- **Matrix load**: coefficient words are row-major; `mat_idx` 0..15 selects `row{mat_idx/4}_{mat_idx%4}`.
  - The first matrix word while `mat_idx == 0` clears `matrix_loaded`.
  - The 16th word sets `matrix_loaded` and wraps `mat_idx` to 0.
- **Matrix write gating**: a matrix word is accepted only when idle. Idle means FIFO empty, `comp_idx == 0` and `out_valid == 0`. In-flight vertices therefore always use one consistent matrix.
- **Vertex assembly**: a vertex word is accepted only when `matrix_loaded == 1` and the FIFO is not full.
  - `comp_idx` 0..3 writes into a staging register.
  - On the 4th component the completed vertex is pushed into the FIFO and `comp_idx` returns to 0.
- **`wr_ready`**: combinational from current state only: the idle condition for matrix words; `matrix_loaded && !full` for vertex words. It must not depend on `out_ready`.
- **Pop/capture**: when `!empty && (!out_valid || out_ready)`:
  - pop the FIFO head;
  - load `out_pixel_{r} <= pixelout_{r}` (combinational product of the current head);
  - set `out_valid`.
- **Output hold**: if `out_valid && out_ready` and the FIFO is empty, clear `out_valid`. While `out_valid && !out_ready`, `out_pixel_*` holds stable.
- **Arithmetic**: no arithmetic in this block. Sums wrap modulo 2^32 inside `matrixmult` and are passed through unchanged.
- **Simultaneous push and pop**: allowed; occupancy is unchanged. Push legality is judged on pre-pop occupancy.
- **`start_new` priority**: it overrides any simultaneous write or pop. That cycle's input word is dropped and `wr_ready` reads 0 during `start_new`.

## Timing
- **Reset values**:
  - `wr_ready` 0 (matrix not loaded and no matrix word pending evaluates low only for vertex words; for matrix words it reads 1 once `reset` deasserts);
  - `out_valid` 0, `out_pixel_*` 0, `matrix_loaded` 0, `vtx_count` 0;
  - `row*` 0, `pixelinT_*` 0; `mat_idx`, `comp_idx`, FIFO pointers 0.
- **Latency**: 4th vertex word accepted at edge N → FIFO head valid after N → result captured at edge N+1 → `out_valid` high after N+1.
- **Throughput**: with `out_ready` held high, one result per cycle, limited by vertex input rate (4 words per vertex).
- **Reset mid-operation**: asynchronous; a partial matrix or vertex is discarded and all outputs return to reset values immediately.
- **Empty FIFO**: `pixelinT_*` output value is don't-care for verification; only captured values are checked.

## Test plan
- **Basic**: load rows [1,1,2,3],[5,6,7,3],[1,2,3,2],[4,5,3,5], then vertex (2,5,3,1), `out_ready` = 1 → `out_pixel` = 16, 64, 23, 47 exactly 1 cycle after the 4th component; `out_valid` for one cycle.
- **Backpressure/full**: `out_ready` = 0, push VTX_DEPTH+1 vertices → FIFO fills, `out_valid` holds the 1st result, `wr_ready` low for vertex words at `vtx_count` = VTX_DEPTH; release `out_ready` → results drain in order with no loss or duplication.
- **Load gating**:
  - vertex word before `matrix_loaded` → `wr_ready` = 0;
  - matrix word with `comp_idx` = 2 or `out_valid` = 1 → `wr_ready` = 0 until idle.
- **Reload**: after results drain, load an identity matrix; vertex (7,8,9,10) → outputs 7, 8, 9, 10. `matrix_loaded` drops on the first reload word.
- **Overflow**: all coefficients and components 0xFFFF → each output = 4·0xFFFE0001 mod 2^32 = 0xFFF80004.
- **Reset and clear**: assert `reset` mid-vertex (`comp_idx` = 2) and with `out_valid` = 1 → all outputs 0 asynchronously. Repeat with `start_new` → FIFO empty, `matrix_loaded` = 0, coefficients retained.
